// File: rtl/ama_riscv_mem_line_fill.sv
// Miss handler between a cache controller and the line memory: optional victim writeback,
// then a single line read, returning the fill with a response timeout and protocol error flags.
module ama_riscv_mem_line_fill #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              miss_dirty,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [DATA_W-1:0] evict_data,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              mem_req_r_valid,
  input  logic              mem_req_r_ready,
  output logic [ADDR_W-1:0] mem_req_r_addr,
  output logic              mem_req_w_valid,
  input  logic              mem_req_w_ready,
  output logic [ADDR_W-1:0] mem_req_w_addr,
  output logic [DATA_W-1:0] mem_req_w_data,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              err_timeout,
  output logic              err_stray
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RD   = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d;
  logic [ADDR_W-1:0]  eaddr_q, eaddr_d;
  logic [DATA_W-1:0]  edata_q, edata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fill_valid_q, fill_valid_d;
  logic [ADDR_W-1:0]  fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0]  fill_data_q, fill_data_d;
  logic               r_valid_q, r_valid_d;
  logic               w_valid_q, w_valid_d;
  logic               err_to_q, err_to_d;
  logic               err_stray_q, err_stray_d;

  // Accept only when the whole miss can proceed; held low while reset is asserted.
  assign miss_ready = rst && (state_q == ST_IDLE) && mem_req_r_ready &&
                      (!miss_dirty || mem_req_w_ready);

  always_comb begin
    state_d      = state_q;
    maddr_d      = maddr_q;
    eaddr_d      = eaddr_q;
    edata_d      = edata_q;
    cnt_d        = cnt_q;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    err_to_d     = err_to_q;
    err_stray_d  = err_stray_q;

    if (mem_rsp_valid && (state_q != ST_WAIT)) begin
      err_stray_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (miss_valid && miss_ready) begin
          maddr_d = miss_addr;
          eaddr_d = evict_addr;
          edata_d = evict_data;
          state_d = miss_dirty ? ST_WB : ST_RD;
        end
      end
      ST_WB: begin
        if (mem_req_w_ready) begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (mem_req_r_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          fill_valid_d = 1'b1;
          fill_addr_d  = maddr_q;
          fill_data_d  = mem_rsp_data;
          state_d      = ST_IDLE;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Request valids are registered copies of the next-state decode, so they never overlap.
    r_valid_d = (state_d == ST_RD);
    w_valid_d = (state_d == ST_WB);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      maddr_q      <= '0;
      eaddr_q      <= '0;
      edata_q      <= '0;
      cnt_q        <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      r_valid_q    <= 1'b0;
      w_valid_q    <= 1'b0;
      err_to_q     <= 1'b0;
      err_stray_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      maddr_q      <= maddr_d;
      eaddr_q      <= eaddr_d;
      edata_q      <= edata_d;
      cnt_q        <= cnt_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      r_valid_q    <= r_valid_d;
      w_valid_q    <= w_valid_d;
      err_to_q     <= err_to_d;
      err_stray_q  <= err_stray_d;
    end
  end

  assign fill_valid      = fill_valid_q;
  assign fill_addr       = fill_addr_q;
  assign fill_data       = fill_data_q;
  assign mem_req_r_valid = r_valid_q;
  assign mem_req_r_addr  = maddr_q;
  assign mem_req_w_valid = w_valid_q;
  assign mem_req_w_addr  = eaddr_q;
  assign mem_req_w_data  = edata_q;
  assign err_timeout     = err_to_q;
  assign err_stray       = err_stray_q;

endmodule

// File: tb/tb_ama_riscv_mem_line_fill.sv
// Bench for ama_riscv_mem_line_fill: memory responder, reference line-memory model and a
// fill scoreboard, directed scenarios followed by randomized misses.
`timescale 1ns/1ps
module tb_ama_riscv_mem_line_fill;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 128;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          miss_valid = 1'b0, miss_ready, miss_dirty = 1'b0;
  logic [AW-1:0] miss_addr = '0, evict_addr = '0;
  logic [DW-1:0] evict_data = '0;
  logic          fill_valid;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic          mem_req_r_valid, mem_req_r_ready = 1'b0;
  logic [AW-1:0] mem_req_r_addr;
  logic          mem_req_w_valid, mem_req_w_ready = 1'b0;
  logic [AW-1:0] mem_req_w_addr;
  logic [DW-1:0] mem_req_w_data;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          err_timeout, err_stray;

  always #5 clk = ~clk;

  ama_riscv_mem_line_fill #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_dirty(miss_dirty), .evict_addr(evict_addr), .evict_data(evict_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_req_r_valid(mem_req_r_valid), .mem_req_r_ready(mem_req_r_ready),
    .mem_req_r_addr(mem_req_r_addr),
    .mem_req_w_valid(mem_req_w_valid), .mem_req_w_ready(mem_req_w_ready),
    .mem_req_w_addr(mem_req_w_addr), .mem_req_w_data(mem_req_w_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .err_timeout(err_timeout), .err_stray(err_stray)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } line_t;
  typedef struct { logic [AW-1:0] addr; logic dirty; logic [AW-1:0] eaddr; logic [DW-1:0] edata; } miss_t;

  miss_t         stim_q[$];
  line_t         exp_fill_q[$];
  line_t         exp_wr_q[$];
  logic [AW-1:0] exp_rd_q[$];
  int            acc_cyc_q[$];
  int            fill_cyc_q[$];
  logic [DW-1:0] phys_mem [int];
  logic [DW-1:0] ref_mem [int];

  int   checks = 0, errors = 0, cyc = 0;
  bit   rdy_rand = 0, mute = 0, inj = 0, rsp_pend = 0, r_seen = 0, err_to_seen = 0;
  int   r_hold = 0, hold_next = 0;
  int   n_rhs = 0, n_whs = 0, n_fill = 0;
  int   last_acc_cyc = 0, first_r_cyc = 0, last_rhs_cyc = 0, last_whs_cyc = 0, last_fill_cyc = 0, err_to_cyc = 0;
  logic [DW-1:0] rsp_pend_data = '0;
  bit   prev_r_stall = 0, prev_w_stall = 0;
  logic [AW-1:0] prev_r_addr = '0, prev_w_addr = '0;
  logic [DW-1:0] prev_w_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_pat(int a);
    logic [7:0] b;
    b = 8'(a) ^ 8'h3c;
    return {16{b}};
  endfunction

  function automatic logic [DW-1:0] phys_rd(int a);
    return phys_mem.exists(a) ? phys_mem[a] : init_pat(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input int act, input int req);
    checks++;
    errors++;
    $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  // One bench cycle: drive inputs at negedge, observe handshakes, then advance to posedge.
  task automatic step();
    miss_t m;
    line_t w;
    logic [AW-1:0] ra;
    @(negedge clk);
    mem_rsp_valid = (rsp_pend && !mute) || inj;
    if (inj) mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
    else if (rsp_pend) mem_rsp_data = rsp_pend_data;
    rsp_pend = 0;
    inj = 0;
    if (r_hold > 0) begin
      mem_req_r_ready = 1'b0;
      r_hold--;
    end else begin
      mem_req_r_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    mem_req_w_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stim_q.size() > 0) begin
      miss_valid = 1'b1;
      miss_addr  = stim_q[0].addr;
      miss_dirty = stim_q[0].dirty;
      evict_addr = stim_q[0].eaddr;
      evict_data = stim_q[0].edata;
    end else begin
      miss_valid = 1'b0;
      miss_dirty = 1'b0;
    end
    #1;
    if (mem_req_r_valid && mem_req_w_valid) fail("rd_wr_overlap", 1, 0);
    if (prev_r_stall) begin
      check("rd_hold_valid", DW'(mem_req_r_valid), DW'(1));
      check("rd_hold_addr", DW'(mem_req_r_addr), DW'(prev_r_addr));
    end
    if (prev_w_stall) begin
      check("wr_hold_valid", DW'(mem_req_w_valid), DW'(1));
      check("wr_hold_addr", DW'(mem_req_w_addr), DW'(prev_w_addr));
      check("wr_hold_data", mem_req_w_data, prev_w_data);
    end
    if (miss_valid && miss_ready) begin
      m = stim_q.pop_front();
      last_acc_cyc = cyc;
      acc_cyc_q.push_back(cyc);
      r_seen = 0;
      if (m.dirty) begin
        ref_mem[int'(m.eaddr)] = m.edata;
        w.addr = m.eaddr;
        w.data = m.edata;
        exp_wr_q.push_back(w);
      end
      exp_rd_q.push_back(m.addr);
      if (!mute) begin
        w.addr = m.addr;
        w.data = ref_rd(int'(m.addr));
        exp_fill_q.push_back(w);
      end
      r_hold = hold_next;
      hold_next = 0;
    end
    if (mem_req_r_valid && !r_seen) begin
      first_r_cyc = cyc;
      r_seen = 1;
    end
    if (mem_req_w_valid && mem_req_w_ready) begin
      n_whs++;
      last_whs_cyc = cyc;
      phys_mem[int'(mem_req_w_addr)] = mem_req_w_data;
      if (exp_wr_q.size() == 0) fail("unexpected_write", n_whs, 0);
      else begin
        w = exp_wr_q.pop_front();
        check("wr_addr", DW'(mem_req_w_addr), DW'(w.addr));
        check("wr_data", mem_req_w_data, w.data);
      end
    end
    if (mem_req_r_valid && mem_req_r_ready) begin
      n_rhs++;
      last_rhs_cyc = cyc;
      check("wb_before_rd", DW'(exp_wr_q.size()), DW'(0));
      if (exp_rd_q.size() == 0) fail("unexpected_read", n_rhs, 0);
      else begin
        ra = exp_rd_q.pop_front();
        check("rd_addr", DW'(mem_req_r_addr), DW'(ra));
      end
      rsp_pend = 1;
      rsp_pend_data = phys_rd(int'(mem_req_r_addr));
    end
    prev_r_stall = mem_req_r_valid && !mem_req_r_ready;
    prev_r_addr  = mem_req_r_addr;
    prev_w_stall = mem_req_w_valid && !mem_req_w_ready;
    prev_w_addr  = mem_req_w_addr;
    prev_w_data  = mem_req_w_data;
    @(posedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((stim_q.size() > 0 || exp_fill_q.size() > 0 || exp_rd_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail("drain_budget", n, budget);
    step();
  endtask

  task automatic push_miss(input logic [AW-1:0] a, input logic d, input logic [AW-1:0] ea,
                           input logic [DW-1:0] ed);
    miss_t m;
    m.addr = a; m.dirty = d; m.eaddr = ea; m.edata = ed;
    stim_q.push_back(m);
  endtask

  // Scoreboard monitor: every fill pulse is matched against the oldest expected fill.
  initial begin
    line_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && err_timeout && !err_to_seen) begin
        err_to_seen = 1;
        err_to_cyc = cyc;
      end
      if (rst && fill_valid) begin
        n_fill++;
        last_fill_cyc = cyc;
        fill_cyc_q.push_back(cyc);
        if (exp_fill_q.size() == 0) fail("unexpected_fill", n_fill, 0);
        else begin
          e = exp_fill_q.pop_front();
          check("fill_addr", DW'(fill_addr), DW'(e.addr));
          check("fill_data", fill_data, e.data);
        end
      end
    end
  end

  initial begin
    int w0, r0, f0, n;
    mem_req_r_ready = 1'b1;
    mem_req_w_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miss_ready", DW'(miss_ready), DW'(0));
    check("rst_outputs", DW'({fill_valid, mem_req_r_valid, mem_req_w_valid, err_timeout, err_stray}), DW'(0));
    check("rst_fill_data", fill_data, DW'(0));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Clean miss, memory holds a5 pattern.
    phys_mem[16] = {16{8'ha5}};
    ref_mem[16]  = {16{8'ha5}};
    w0 = n_whs;
    push_miss(16'h010, 1'b0, 16'h0077, {4{$urandom}});
    drain(50);
    check("t1_rd_latency", DW'(first_r_cyc - last_acc_cyc), DW'(1));
    check("t1_fill_latency", DW'(last_fill_cyc - last_acc_cyc), DW'(3));
    check("t1_no_write", DW'(n_whs - w0), DW'(0));

    // Dirty miss then refetch of the evicted line.
    push_miss(16'h030, 1'b1, 16'h020, {16{8'h11}});
    drain(50);
    check("t2_wr_cycle", DW'(last_whs_cyc - last_acc_cyc), DW'(1));
    check("t2_rd_cycle", DW'(last_rhs_cyc - last_acc_cyc), DW'(2));
    check("t2_fill_cycle", DW'(last_fill_cyc - last_acc_cyc), DW'(4));
    push_miss(16'h020, 1'b0, 16'h0, '0);
    drain(50);
    check("t2_refetch_data", fill_data, {16{8'h11}});

    // Read port stalled 5 cycles in RD.
    r0 = n_rhs;
    hold_next = 5;
    push_miss(16'h040, 1'b0, 16'h0, '0);
    drain(50);
    check("t3_one_read", DW'(n_rhs - r0), DW'(1));
    check("t3_rd_cycle", DW'(last_rhs_cyc - last_acc_cyc), DW'(6));
    check("t3_fill_after_ready", DW'(last_fill_cyc - last_rhs_cyc), DW'(2));

    // Silent responder: timeout.
    mute = 1;
    f0 = n_fill;
    push_miss(16'h050, 1'b0, 16'h0, '0);
    drain(50);
    n = 0;
    while (!err_to_seen && n < 30) begin
      step();
      n++;
    end
    if (!err_to_seen) fail("t4_timeout_never", n, 30);
    else check("t4_timeout_cycle", DW'(err_to_cyc - last_rhs_cyc), DW'(TO + 1));
    step();
    #1;
    check("t4_miss_ready", DW'(miss_ready), DW'(1));
    check("t4_no_fill", DW'(n_fill - f0), DW'(0));
    check("t4_no_stray", DW'(err_stray), DW'(0));

    // Reset during WAIT, then a late response.
    push_miss(16'h060, 1'b0, 16'h0, '0);
    drain(50);
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_rst_flags", DW'({fill_valid, mem_req_r_valid, mem_req_w_valid, err_timeout, err_stray}), DW'(0));
    check("t5_rst_miss_ready", DW'(miss_ready), DW'(0));
    check("t5_rst_fill", {fill_data[DW-1:AW], fill_addr}, DW'(0));
    rsp_pend = 0;
    prev_r_stall = 0;
    prev_w_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    inj = 1;
    step();
    step();
    #1;
    check("t5_err_stray", DW'(err_stray), DW'(1));
    check("t5_no_fill", DW'(n_fill - f0), DW'(0));
    mute = 0;

    // Back-to-back misses with miss_valid held.
    acc_cyc_q.delete();
    fill_cyc_q.delete();
    push_miss(16'h001, 1'b0, 16'h0, '0);
    push_miss(16'h002, 1'b0, 16'h0, '0);
    drain(50);
    if (acc_cyc_q.size() != 2 || fill_cyc_q.size() != 2) fail("t6_counts", fill_cyc_q.size(), 2);
    else begin
      check("t6_second_accept", DW'(acc_cyc_q[1] - acc_cyc_q[0]), DW'(3));
      check("t6_first_fill", DW'(fill_cyc_q[0] - acc_cyc_q[0]), DW'(3));
      check("t6_second_fill", DW'(fill_cyc_q[1] - acc_cyc_q[0]), DW'(6));
    end

    // Randomized misses with random ready backpressure.
    rdy_rand = 1;
    for (int i = 0; i < 40; i++) begin
      push_miss(16'h100 + 16'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                16'h100 + 16'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
    end
    drain(4000);
    check("end_no_timeout", DW'(err_timeout), DW'(0));
    check("end_stray_sticky", DW'(err_stray), DW'(1));
    check("end_queues_empty", DW'(exp_fill_q.size() + exp_wr_q.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
